sprite_motion_ctrl: RTL

Per-frame position controller for one sprite renderer. Once per video frame it computes a new top-left (x, y) for the sprite and drives the renderer's x/y inputs. Updates happen only during vertical blanking, so the renderer never sees a coordinate change mid-frame. The block supports host position loads, pause, and edge bounce.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_axis_step.sv | 48 ++++
 rtl/sprite_motion_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  localparam int SCREEN_W_DEF = 1024;
  localparam int SCREEN_H_DEF = 768;

  // Largest legal top-left coordinate on one axis: screen extent minus sprite extent.
  function automatic logic [11:0] calc_limit(input int screen, input int size);
    return 12'(screen - size);
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational one-axis step with edge clamp; edge bounce only when SPRITE_BOUNCE_EN is defined.
module sprite_axis_step #(
  parameter int POS_W = 11
)(
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_dir,
  input  logic [3:0]       i_speed,
  input  logic [11:0]      i_limit,
  output logic [POS_W-1:0] o_next,
  output logic             o_toggle
);

`ifdef SPRITE_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic [11:0] w_pos;
  logic [11:0] w_sum;
  logic [11:0] w_next;
  logic        w_hit;

  // Full 12-bit math so the overshoot past the limit is seen before clamping.
  always_comb begin
    w_pos  = 12'(i_pos);
    w_sum  = w_pos + 12'(i_speed);
    w_next = w_sum;
    w_hit  = 1'b0;
    if (!i_dir) begin
      if (w_sum >= i_limit) begin
        w_next = i_limit;
        w_hit  = 1'b1;
      end
    end else begin
      if (w_pos <= 12'(i_speed)) begin
        w_next = 12'd0;
        w_hit  = 1'b1;
      end else begin
        w_next = w_pos - 12'(i_speed);
      end
    end
  end

  assign o_next   = POS_W'(w_next);
  assign o_toggle = BOUNCE & w_hit;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: updates x/y during vertical blank only.
// Edge bounce is enabled by defining SPRITE_BOUNCE_EN (see sprite_axis_step).
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 256,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
)(
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [3:0]  speed,
  input  logic        pause,
  input  logic        load,
  input  logic [10:0] load_x,
  input  logic [9:0]  load_y,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [11:0] XMAX = calc_limit(SCREEN_W, WIDTH);
  localparam logic [11:0] YMAX = calc_limit(SCREEN_H, HEIGHT);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_boundary;
  logic [10:0] r_x, r_nx, r_lx;
  logic [9:0]  r_y, r_ny, r_ly;
  logic        r_dx, r_dy, r_tx, r_ty;
  logic        r_pend, r_tick, r_busy;
  logic [10:0] w_nx;
  logic [9:0]  w_ny;
  logic        w_tx, w_ty;

  sprite_axis_step #(.POS_W(11)) u_step_x (
    .i_pos(r_x), .i_dir(r_dx), .i_speed(speed), .i_limit(XMAX),
    .o_next(w_nx), .o_toggle(w_tx)
  );

  sprite_axis_step #(.POS_W(10)) u_step_y (
    .i_pos(r_y), .i_dir(r_dy), .i_speed(speed), .i_limit(YMAX),
    .o_next(w_ny), .o_toggle(w_ty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_boundary) w_state_next = CALC_X;
      CALC_X:  w_state_next = CALC_Y;
      CALC_Y:  w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_boundary <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_lx       <= '0;
      r_ly       <= '0;
      r_dx       <= 1'b0;
      r_dy       <= 1'b0;
      r_tx       <= 1'b0;
      r_ty       <= 1'b0;
      r_pend     <= 1'b0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_boundary <= (hcount == 11'd0) && (vcount == 10'(SCREEN_H));
      r_tick     <= (w_state_next == COMMIT);
      r_busy     <= (w_state_next != IDLE);

      if (r_state == CALC_X) begin
        r_nx <= w_nx;
        r_tx <= w_tx;
      end
      if (r_state == CALC_Y) begin
        r_ny <= w_ny;
        r_ty <= w_ty;
      end

      // A strobe landing in COMMIT re-arms the pending load for the next frame.
      if (load) begin
        r_pend <= 1'b1;
        r_lx   <= load_x;
        r_ly   <= load_y;
      end else if (r_state == COMMIT) begin
        r_pend <= 1'b0;
      end

      if (r_state == COMMIT) begin
        if (r_pend) begin
          r_x <= (12'(r_lx) > XMAX) ? 11'(XMAX) : r_lx;
          r_y <= (12'(r_ly) > YMAX) ? 10'(YMAX) : r_ly;
        end else if (!pause) begin
          r_x  <= r_nx;
          r_y  <= r_ny;
          r_dx <= r_dx ^ r_tx;
          r_dy <= r_dy ^ r_ty;
        end
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign dir_x      = r_dx;
  assign dir_y      = r_dy;
  assign frame_tick = r_tick;
  assign busy       = r_busy;

endmodule
